// File: rtl/multicycle_controller.sv
// Control unit for the 8-bit multicycle MIPS core.
// A Moore FSM steps through four byte fetches, decode and per-instruction
// execute/memory/writeback states. An internal ALU decoder produces alucont.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       memread,
   output logic       memwrite,
   output logic       iord,
   output logic [3:0] irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucont,
   output logic [1:0] pcsource,
   output logic       pcen,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH1  = 4'd0;
   localparam logic [3:0] S_FETCH2  = 4'd1;
   localparam logic [3:0] S_FETCH3  = 4'd2;
   localparam logic [3:0] S_FETCH4  = 4'd3;
   localparam logic [3:0] S_DECODE  = 4'd4;
   localparam logic [3:0] S_MEMADR  = 4'd5;
   localparam logic [3:0] S_LBRD    = 4'd6;
   localparam logic [3:0] S_LBWR    = 4'd7;
   localparam logic [3:0] S_SBWR    = 4'd8;
   localparam logic [3:0] S_RTYPEEX = 4'd9;
   localparam logic [3:0] S_RTYPEWR = 4'd10;
   localparam logic [3:0] S_BEQEX   = 4'd11;
   localparam logic [3:0] S_JEX     = 4'd12;
   localparam logic [3:0] S_ADDIEX  = 4'd13;
   localparam logic [3:0] S_ADDIWR  = 4'd14;

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic [1:0] aluop_s;
   logic       pcwrite_s;
   logic       pcwritecond_s;

   // Maps the FSM's aluop and the instruction funct field to an ALU control code.
   function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
      logic [2:0] res;
      res = 3'b010;
      case (aluop)
         2'b00: res = 3'b010;
         2'b01: res = 3'b110;
         2'b10: begin
            case (fn)
               6'b100000: res = 3'b010;
               6'b100010: res = 3'b110;
               6'b100100: res = 3'b000;
               6'b100101: res = 3'b001;
               6'b101010: res = 3'b111;
               default:   res = 3'b010;
            endcase
         end
         default: res = 3'b010;
      endcase
      return res;
   endfunction

   // State register with synchronous active-low reset to FETCH1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH1;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the unused code falls back to FETCH1.
   always_comb begin
      state_d = S_FETCH1;
      case (state_q)
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: state_d = S_FETCH3;
         S_FETCH3: state_d = S_FETCH4;
         S_FETCH4: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LB, OP_SB: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_J:         state_d = S_JEX;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH1;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LB) begin
               state_d = S_LBRD;
            end else begin
               state_d = S_SBWR;
            end
         end
         S_LBRD:    state_d = S_LBWR;
         S_RTYPEEX: state_d = S_RTYPEWR;
         S_ADDIEX:  state_d = S_ADDIWR;
         S_LBWR, S_SBWR, S_RTYPEWR, S_BEQEX, S_JEX, S_ADDIWR: state_d = S_FETCH1;
         default:   state_d = S_FETCH1;
      endcase
   end

   // Moore outputs decoded from the state; all forced inactive while in reset.
   always_comb begin
      memread       = 1'b0;
      memwrite      = 1'b0;
      iord          = 1'b0;
      irwrite       = 4'b0000;
      regdst        = 1'b0;
      memtoreg      = 1'b0;
      regwrite      = 1'b0;
      alusrca       = 1'b0;
      alusrcb       = 2'b00;
      pcsource      = 2'b00;
      aluop_s       = 2'b00;
      pcwrite_s     = 1'b0;
      pcwritecond_s = 1'b0;
      if (!rst_n) begin
         aluop_s = 2'b00;
      end else begin
         case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
               memread   = 1'b1;
               alusrcb   = 2'b01;
               pcwrite_s = 1'b1;
               irwrite   = 4'b0001 << state_q[1:0];
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            S_LBRD: begin
               memread = 1'b1;
               iord    = 1'b1;
            end
            S_LBWR: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
            end
            S_SBWR: begin
               memwrite = 1'b1;
               iord     = 1'b1;
            end
            S_RTYPEEX: begin
               alusrca = 1'b1;
               aluop_s = 2'b10;
            end
            S_RTYPEWR: begin
               regdst   = 1'b1;
               regwrite = 1'b1;
            end
            S_BEQEX: begin
               alusrca       = 1'b1;
               aluop_s       = 2'b01;
               pcwritecond_s = 1'b1;
               pcsource      = 2'b01;
            end
            S_JEX: begin
               pcwrite_s = 1'b1;
               pcsource  = 2'b10;
            end
            S_ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            S_ADDIWR:  regwrite = 1'b1;
            default:   aluop_s = 2'b00;
         endcase
      end
      alucont = alu_decode(aluop_s, funct);
      pcen    = pcwrite_s | (pcwritecond_s & zero);
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams compared against a per-instruction model.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       memread, memwrite, iord, regdst, memtoreg, regwrite, alusrca, pcen;
   logic [3:0] irwrite, state;
   logic [1:0] alusrcb, pcsource;
   logic [2:0] alucont;

   int n_cmp = 0;
   int n_fail = 0;

   logic [22:0] obs_q[$];
   logic [22:0] exp_q[$];
   wire  [22:0] obs_s = {memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
                         alusrca, alusrcb, alucont, pcsource, pcen, state};

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .alucont(alucont), .pcsource(pcsource), .pcen(pcen),
      .state(state)
   );

   always #5 clk = ~clk;

   // Pack one cycle's expected outputs in the same order as obs_s.
   function automatic logic [22:0] mk(input logic [3:0] st, input logic mr, input logic mw,
                                      input logic io, input logic [3:0] irw, input logic rd,
                                      input logic m2r, input logic rw, input logic sa,
                                      input logic [1:0] sb, input logic [2:0] ac,
                                      input logic [1:0] ps, input logic pe);
      return {mr, mw, io, irw, rd, m2r, rw, sa, sb, ac, ps, pe, st};
   endfunction

   function automatic logic [2:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected cycle-by-cycle trace of one whole instruction, FETCH1 onward.
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z);
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(mk(k[3:0], 1'b1, 1'b0, 1'b0, 4'(1 << k), 1'b0, 1'b0, 1'b0, 1'b0,
                            2'b01, 3'b010, 2'b00, 1'b1));
      end
      exp_q.push_back(mk(4'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0));
      if (o == 6'b100000 || o == 6'b101000) begin
         exp_q.push_back(mk(4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0));
         if (o == 6'b100000) begin
            exp_q.push_back(mk(4'd6, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0));
            exp_q.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0));
         end else begin
            exp_q.push_back(mk(4'd8, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0));
         end
      end else if (o == 6'b000000) begin
         exp_q.push_back(mk(4'd9, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, rtype_alu(f), 2'b00, 1'b0));
         exp_q.push_back(mk(4'd10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0));
      end else if (o == 6'b000100) begin
         exp_q.push_back(mk(4'd11, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, z));
      end else if (o == 6'b000010) begin
         exp_q.push_back(mk(4'd12, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b10, 1'b1));
      end else if (o == 6'b001000) begin
         exp_q.push_back(mk(4'd13, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0));
         exp_q.push_back(mk(4'd14, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0));
      end
   endtask

   // Drive one instruction for n cycles and record the outputs (no checking here).
   task automatic run_collect(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
      obs_q.delete();
      op = o; funct = f; zero = z;
      for (int i = 0; i < n; i++) begin
         #1;
         obs_q.push_back(obs_s);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [22:0] e;
      rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      e = mk(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0);
      n_cmp++;
      if (obs_s !== e) begin
         n_fail++; $display("FAIL reset_hold: got %h expected %h", obs_s, e);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (memread !== 1'b1 || irwrite !== 4'b0001 || pcen !== 1'b1 || state !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_release: got mr=%b irw=%b pcen=%b st=%0d expected 1 0001 1 0",
                  memread, irwrite, pcen, state);
      end
   endtask

   task automatic test_lb();
      build(6'b100000, 6'd0, 1'b0);
      run_collect(6'b100000, 6'd0, 1'b0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL lb[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (exp_q.size() != 8 || state !== 4'd0) begin
         n_fail++; $display("FAIL lb_cpi: got state %0d after %0d cycles expected 0 after 8", state, exp_q.size());
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fs [2] = '{6'b100010, 6'b101010};
      logic [2:0] ac [2] = '{3'b110, 3'b111};
      for (int t = 0; t < 2; t++) begin
         build(6'b000000, fs[t], 1'b0);
         run_collect(6'b000000, fs[t], 1'b0, exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rtype%0d[%0d]: got %h expected %h", t, i, obs_q[i], exp_q[i]);
            end
         end
         n_cmp++;
         if (obs_q[5][9:7] !== ac[t]) begin
            n_fail++; $display("FAIL rtype%0d_alucont: got %b expected %b", t, obs_q[5][9:7], ac[t]);
         end
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         build(6'b000100, 6'd0, z[0]);
         run_collect(6'b000100, 6'd0, z[0], exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL beq_z%0d[%0d]: got %h expected %h", z, i, obs_q[i], exp_q[i]);
            end
         end
         n_cmp++;
         if (state !== 4'd0 || obs_q[5][4] !== z[0]) begin
            n_fail++; $display("FAIL beq_z%0d_end: got state %0d pcen %b expected 0 %b", z, state, obs_q[5][4], z[0]);
         end
      end
   endtask

   task automatic test_j_sb_illegal();
      logic [5:0] ops [3] = '{6'b000010, 6'b101000, 6'b111111};
      for (int t = 0; t < 3; t++) begin
         build(ops[t], 6'h2a, 1'b0);
         run_collect(ops[t], 6'h2a, 1'b0, exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL op%b[%0d]: got %h expected %h", ops[t], i, obs_q[i], exp_q[i]);
            end
         end
         n_cmp++;
         if (state !== 4'd0) begin
            n_fail++; $display("FAIL op%b_return: got state %0d expected 0", ops[t], state);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [22:0] e;
      run_collect(6'b100000, 6'd0, 1'b0, 6);
      #1;
      n_cmp++;
      if (state !== 4'd6 || memread !== 1'b1 || iord !== 1'b1) begin
         n_fail++; $display("FAIL mid_lbrd: got st=%0d mr=%b iord=%b expected 6 1 1", state, memread, iord);
      end
      rst_n = 1'b0;
      #1;
      e = mk(4'd6, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0);
      n_cmp++;
      if (obs_s !== e) begin
         n_fail++; $display("FAIL mid_forced: got %h expected %h", obs_s, e);
      end
      @(posedge clk);
      #1;
      e = mk(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0);
      n_cmp++;
      if (obs_s !== e) begin
         n_fail++; $display("FAIL mid_after_edge: got %h expected %h", obs_s, e);
      end
      rst_n = 1'b1;
      #1;
      build(6'b100000, 6'd0, 1'b0);
      n_cmp++;
      if (obs_s !== exp_q[0]) begin
         n_fail++; $display("FAIL mid_refetch: got %h expected %h", obs_s, exp_q[0]);
      end
   endtask

   task automatic test_random();
      logic [5:0] op_tab [7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
      logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] o, f;
      logic z;
      for (int n = 0; n < 40; n++) begin
         o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : op_tab[$urandom_range(0, 6)];
         f = ($urandom_range(0, 4) == 4) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
         z = 1'($urandom);
         build(o, f, z);
         run_collect(o, f, z, exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rand%0d op=%b fn=%b z=%b [%0d]: got %h expected %h",
                                  n, o, f, z, i, obs_q[i], exp_q[i]);
            end
            n_cmp++;
            if (!$onehot0(obs_q[i][19:16]) || (obs_q[i][22] && obs_q[i][21]) || (obs_q[i][13] && obs_q[i][21])) begin
               n_fail++; $display("FAIL rand%0d_invariant[%0d]: got %h expected one-hot irwrite and exclusive strobes",
                                  n, i, obs_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_rtype();
      test_beq();
      test_j_sb_illegal();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the 8-bit multicycle MIPS core; drives the control inputs of the datapath and consumes its op/funct/zero status outputs.
- Moore FSM sequences four byte-wide instruction fetches, decode, then per-instruction execute/memory/writeback states.
- Internal ALU decoder maps aluop and funct to alucont.
- Supports lb, sb, R-type (add/sub/and/or/slt), beq, j, addi.

Parameters:
- none; all widths are fixed by the 8-bit datapath.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- op  input  6  instr[31:26] from datapath
- funct  input  6  instr[5:0] from datapath
- zero  input  1  ALU result == 0, from datapath
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- irwrite  output  4  one-hot byte enable of the instruction register
- regdst  output  1  1 = rd is destination, 0 = rt
- memtoreg  output  1  1 = write memory data to register
- regwrite  output  1  register file write enable
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 = B, 01 = constant 1, 10 = imm, 11 = imm (branch offset)
- alucont  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- pcen  output  1  PC write enable
- state  output  4  current state, for debug

Behaviour:
- State register is 4 bits. Encoding: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14. Code 15 is illegal and goes to FETCH1.
- Reset: when rst_n=0 at a clk edge, state <= FETCH1. While rst_n=0, every output is forced to 0 combinationally (alucont=010, state shows the register). First active cycle after rst_n rises is FETCH1. Reset mid-instruction aborts it with no write of any kind.
- Transitions:
  - FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE.
  - DECODE by op: 100000 (lb) or 101000 (sb) -> MEMADR; 000000 (R-type) -> RTYPEEX; 000100 (beq) -> BEQEX; 000010 (j) -> JEX; 001000 (addi) -> ADDIEX; any other op -> FETCH1 (executed as a nop).
  - MEMADR -> LBRD if op=lb, otherwise SBWR. LBRD -> LBWR.
  - RTYPEEX -> RTYPEWR. ADDIEX -> ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR -> FETCH1.
- Outputs per state (any signal not listed is 0; aluop=00 unless stated):
  - FETCHn: memread=1, alusrcb=01, pcwrite=1. irwrite = 0001, 0010, 0100, 1000 for n = 1..4.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JEX: pcwrite=1, pcsource=10.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWR: regwrite=1.
- pcen = pcwrite | (pcwritecond & zero). This is combinational in zero within the same cycle; there is no registered delay.
- ALU decoder: aluop 00 -> 010; aluop 01 -> 110. For aluop 10, funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010. aluop 11 is never generated.
- Cycles per instruction, FETCH1 to the next FETCH1: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, unknown op 5.
- Invariants: irwrite is one-hot or zero; memread and memwrite are never both 1; regwrite and memwrite are never both 1.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with op=000000 -> all enables 0, state=0; release -> memread=1, irwrite=0001, pcen=1 in the first cycle.
- lb: op=100000 -> states 0,1,2,3,4,5,6,7,0; LBRD has iord=1 and memread=1; LBWR has regwrite=1, memtoreg=1, regdst=0.
- R-type sub then slt: funct=100010 -> alucont=110 in RTYPEEX, regdst=1 and regwrite=1 in RTYPEWR; repeat with funct=101010 -> alucont=111.
- beq: op=000100 with zero=1 -> pcen=1 and pcsource=01 in BEQEX; with zero=0 -> pcen=0; state returns to FETCH1 after 6 cycles in both cases.
- j, sb and illegal op: op=000010 -> JEX with pcen=1, pcsource=10. op=101000 -> SBWR with memwrite=1, iord=1, regwrite=0. op=111111 -> DECODE then FETCH1, no regwrite or memwrite pulse.
- Reset mid-instruction: assert rst_n=0 during LBRD -> next state=FETCH1 and no regwrite pulse.
